alu_share_arbiter: RTL and testbench

- Shares one combinational RISC-V ALU between two requesters: port 0 (main execute path) and port 1 (branch/compare helper).
- Round-robin arbitration, valid/ready request handshake and registered per-port responses with backpressure.
- One operation in flight at a time.
- Sits between the requesters and the ALU. Drives ALU control and operands from registers; captures ALU result and branch flags.

---
 rtl/alu_share_arbiter_if.sv | 63 ++++++
 rtl/alu_share_arbiter.sv | 136 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// Request/response/ALU bundle for alu_share_arbiter; slave is the arbiter view, master the requester+ALU view.
// Under ALU_ILLEGAL_OP_CHK_EN the bundle also carries the per-port error flags.
interface alu_share_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int FLAG_W = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic [CTRL_W-1:0] req0_ctrl;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              req1_valid;
  logic              req1_ready;
  logic [CTRL_W-1:0] req1_ctrl;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [DATA_W-1:0] rsp0_data;
  logic [FLAG_W-1:0] rsp0_flag;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp1_data;
  logic [FLAG_W-1:0] rsp1_flag;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_data;
  logic [FLAG_W-1:0] alu_flag;
`ifdef ALU_ILLEGAL_OP_CHK_EN
  logic              rsp0_err;
  logic              rsp1_err;
`endif

  modport slave (
    input  req0_valid, req0_ctrl, req0_a, req0_b,
    input  req1_valid, req1_ctrl, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp0_flag,
    output rsp1_valid, rsp1_data, rsp1_flag,
    input  rsp0_ready, rsp1_ready,
`ifdef ALU_ILLEGAL_OP_CHK_EN
    output rsp0_err, rsp1_err,
`endif
    output alu_ctrl, alu_a, alu_b,
    input  alu_data, alu_flag
  );

  modport master (
    output req0_valid, req0_ctrl, req0_a, req0_b,
    output req1_valid, req1_ctrl, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp0_flag,
    input  rsp1_valid, rsp1_data, rsp1_flag,
    output rsp0_ready, rsp1_ready,
`ifdef ALU_ILLEGAL_OP_CHK_EN
    input  rsp0_err, rsp1_err,
`endif
    input  alu_ctrl, alu_a, alu_b,
    output alu_data, alu_flag
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters; one op in flight, response 2 cycles after accept.
// Optional ALU_ILLEGAL_OP_CHK_EN: unsupported opcodes bypass the ALU and respond next cycle with err=1.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int FLAG_W = 4
) (
  input logic                clk,
  input logic                rst_n,
  alu_share_arbiter_if.slave arb
);
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t                 r_state;
  logic                   r_owner;
  logic                   r_last_grant;
  logic [CTRL_W-1:0]      r_alu_ctrl;
  logic [DATA_W-1:0]      r_alu_a;
  logic [DATA_W-1:0]      r_alu_b;
  logic [1:0]             r_rsp_valid;
  logic [1:0][DATA_W-1:0] r_rsp_data;
  logic [1:0][FLAG_W-1:0] r_rsp_flag;
`ifdef ALU_ILLEGAL_OP_CHK_EN
  logic [1:0]             r_rsp_err;
  logic                   w_illegal;
`endif

  logic              w_grant;
  logic              w_accept;
  logic              w_own_rsp_ready;
  logic [CTRL_W-1:0] w_sel_ctrl;
  logic [DATA_W-1:0] w_sel_a;
  logic [DATA_W-1:0] w_sel_b;
  logic [FLAG_W-1:0] w_masked_flag;

  // A lone requester always wins; on a tie the port that did not go last wins.
  always_comb begin
    w_grant = 1'b0;
    if (arb.req0_valid && arb.req1_valid) w_grant = ~r_last_grant;
    else if (arb.req1_valid)              w_grant = 1'b1;
  end

  assign w_accept        = (r_state == S_IDLE) && (arb.req0_valid || arb.req1_valid);
  assign arb.req0_ready  = (r_state == S_IDLE) && arb.req0_valid && !w_grant;
  assign arb.req1_ready  = (r_state == S_IDLE) && arb.req1_valid &&  w_grant;
  assign w_sel_ctrl      = w_grant ? arb.req1_ctrl : arb.req0_ctrl;
  assign w_sel_a         = w_grant ? arb.req1_a    : arb.req0_a;
  assign w_sel_b         = w_grant ? arb.req1_b    : arb.req0_b;
  assign w_own_rsp_ready = r_owner ? arb.rsp1_ready : arb.rsp0_ready;

  // The ALU only refreshes flags on compare opcodes, so anything else must not pass them on.
  always_comb begin
    w_masked_flag = '0;
    if (r_alu_ctrl == CTRL_W'(1))      w_masked_flag[1:0] = arb.alu_flag[1:0];
    else if (r_alu_ctrl == CTRL_W'(3)) w_masked_flag[3:2] = arb.alu_flag[3:2];
  end

`ifdef ALU_ILLEGAL_OP_CHK_EN
  assign w_illegal = (w_sel_ctrl == CTRL_W'(4)) || (w_sel_ctrl >= CTRL_W'(10));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_alu_ctrl   <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_rsp_valid  <= '0;
      r_rsp_data   <= '0;
      r_rsp_flag   <= '0;
`ifdef ALU_ILLEGAL_OP_CHK_EN
      r_rsp_err    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_owner      <= w_grant;
            r_last_grant <= w_grant;
`ifdef ALU_ILLEGAL_OP_CHK_EN
            if (w_illegal) begin
              r_state              <= S_RESP;
              r_rsp_valid[w_grant] <= 1'b1;
              r_rsp_data[w_grant]  <= '0;
              r_rsp_flag[w_grant]  <= '0;
              r_rsp_err[w_grant]   <= 1'b1;
            end else begin
              r_state    <= S_EXEC;
              r_alu_ctrl <= w_sel_ctrl;
              r_alu_a    <= w_sel_a;
              r_alu_b    <= w_sel_b;
            end
`else
            r_state    <= S_EXEC;
            r_alu_ctrl <= w_sel_ctrl;
            r_alu_a    <= w_sel_a;
            r_alu_b    <= w_sel_b;
`endif
          end
        end
        S_EXEC: begin
          r_state              <= S_RESP;
          r_rsp_valid[r_owner] <= 1'b1;
          r_rsp_data[r_owner]  <= arb.alu_data;
          r_rsp_flag[r_owner]  <= w_masked_flag;
`ifdef ALU_ILLEGAL_OP_CHK_EN
          r_rsp_err[r_owner]   <= 1'b0;
`endif
        end
        S_RESP: begin
          if (w_own_rsp_ready) begin
            r_rsp_valid <= '0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign arb.alu_ctrl   = r_alu_ctrl;
  assign arb.alu_a      = r_alu_a;
  assign arb.alu_b      = r_alu_b;
  assign arb.rsp0_valid = r_rsp_valid[0];
  assign arb.rsp1_valid = r_rsp_valid[1];
  assign arb.rsp0_data  = r_rsp_data[0];
  assign arb.rsp1_data  = r_rsp_data[1];
  assign arb.rsp0_flag  = r_rsp_flag[0];
  assign arb.rsp1_flag  = r_rsp_flag[1];
`ifdef ALU_ILLEGAL_OP_CHK_EN
  assign arb.rsp0_err   = r_rsp_err[0];
  assign arb.rsp1_err   = r_rsp_err[1];
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU (add/sub/and/slt, flags from signed compare).
module tb_alu_share_arbiter;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  alu_share_arbiter_if bus ();

  alu_share_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (bus.alu_ctrl)
      4'b0000: bus.alu_data = bus.alu_a + bus.alu_b;
      4'b0001: bus.alu_data = bus.alu_a - bus.alu_b;
      4'b0010: bus.alu_data = bus.alu_a & bus.alu_b;
      4'b0011: bus.alu_data = {31'b0, ($signed(bus.alu_a) < $signed(bus.alu_b))};
      default: bus.alu_data = bus.alu_a ^ bus.alu_b;
    endcase
    bus.alu_flag = {($signed(bus.alu_a) >= $signed(bus.alu_b)),
                    ($signed(bus.alu_a) <  $signed(bus.alu_b)),
                    (bus.alu_a != bus.alu_b),
                    (bus.alu_a == bus.alu_b)};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drive_req(input int port, input logic v, input logic [3:0] c,
                           input logic [31:0] a, input logic [31:0] b);
    if (port == 0) begin
      bus.req0_valid = v; bus.req0_ctrl = c; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_ctrl = c; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  function automatic logic rdy(input int port);
    return (port == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  function automatic logic vld(input int port);
    return (port == 0) ? bus.rsp0_valid : bus.rsp1_valid;
  endfunction

  function automatic logic [31:0] dat(input int port);
    return (port == 0) ? bus.rsp0_data : bus.rsp1_data;
  endfunction

  function automatic logic [3:0] flg(input int port);
    return (port == 0) ? bus.rsp0_flag : bus.rsp1_flag;
  endfunction

  // One isolated op on one port: ready in the request cycle, EXEC cycle, then response, then idle.
  task automatic run_op(input string tag, input int port, input logic [3:0] c,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ed, input logic [3:0] ef);
    tick(); drive_req(port, 1'b1, c, a, b); settle();
    check({tag, "_rdy"}, rdy(port), 1);
    check({tag, "_other_rdy"}, rdy(1 - port), 0);
    tick(); drive_req(port, 1'b0, c, a, b); settle();
    check({tag, "_exec_vld"}, vld(port), 0);
    tick(); settle();
    check({tag, "_vld"}, vld(port), 1);
    check({tag, "_other_vld"}, vld(1 - port), 0);
    check({tag, "_data"}, dat(port), ed);
    check({tag, "_flag"}, flg(port), ef);
    tick(); settle();
    check({tag, "_vld_drop"}, vld(port), 0);
  endtask

  initial begin
    int grants[$];
    int rsp_cnt;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    drive_req(0, 1'b0, 4'h0, 32'd0, 32'd0);
    drive_req(1, 1'b0, 4'h0, 32'd0, 32'd0);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;

    #2;
    check("rst_alu_ctrl", bus.alu_ctrl, 0);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_rsp_vld", {bus.rsp0_valid, bus.rsp1_valid}, 0);
    check("rst_rdy", {bus.req0_ready, bus.req1_ready}, 0);
    check("rst_rsp_data", {bus.rsp0_data, bus.rsp1_data}, 0);
    tick(); tick();
    rst_n = 1'b1;
    settle();
    check("post_rst_vld", {bus.rsp0_valid, bus.rsp1_valid}, 0);

    run_op("single", 0, 4'b0000, 32'd5, 32'd7, 32'd12, 4'b0000);
    run_op("cmp_eq", 1, 4'b0001, 32'd9, 32'd9, 32'd0, 4'b0001);
    run_op("cmp_lt", 1, 4'b0011, 32'd3, 32'd8, 32'd1, 4'b0100);
    run_op("add_noflag", 1, 4'b0000, 32'd3, 32'd8, 32'd11, 4'b0000);

    // Both ports requesting continuously: grants must alternate starting at port 0.
    tick();
    drive_req(0, 1'b1, 4'b0000, 32'd1, 32'd1);
    drive_req(1, 1'b1, 4'b0000, 32'd10, 32'd20);
    rsp_cnt = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      settle();
      check("rr_one_hot_rdy", bus.req0_ready && bus.req1_ready, 0);
      if (bus.req0_ready) grants.push_back(0);
      if (bus.req1_ready) grants.push_back(1);
      if (bus.rsp0_valid) begin
        rsp_cnt++;
        check("rr_rsp0_data", bus.rsp0_data, 32'd2);
      end
      if (bus.rsp1_valid) begin
        rsp_cnt++;
        check("rr_rsp1_data", bus.rsp1_data, 32'd30);
      end
      tick();
    end
    drive_req(0, 1'b0, 4'b0000, 32'd0, 32'd0);
    drive_req(1, 1'b0, 4'b0000, 32'd0, 32'd0);
    check("rr_rsp_count", rsp_cnt, 4);
    check("rr_grant_count", grants.size(), 4);
    for (int i = 0; i < grants.size() && i < 4; i++)
      check("rr_grant_order", grants[i], i % 2);
    settle();
    check("rr_idle_after", {bus.rsp0_valid, bus.rsp1_valid}, 0);

    // Port 0 response held off for 5 cycles while port 1 waits.
    tick(); drive_req(0, 1'b1, 4'b0000, 32'd100, 32'd23); settle();
    check("bp_rdy0", bus.req0_ready, 1);
    tick();
    drive_req(0, 1'b0, 4'b0000, 32'd0, 32'd0);
    drive_req(1, 1'b1, 4'b0001, 32'd4, 32'd4);
    bus.rsp0_ready = 1'b0;
    settle();
    check("bp_exec_rdy1", bus.req1_ready, 0);
    for (int cyc = 0; cyc < 5; cyc++) begin
      tick(); settle();
      check("bp_hold_vld", bus.rsp0_valid, 1);
      check("bp_hold_data", bus.rsp0_data, 32'd123);
      check("bp_hold_rdy1", bus.req1_ready, 0);
    end
    tick(); bus.rsp0_ready = 1'b1; settle();
    check("bp_hs_rdy1", bus.req1_ready, 0);
    tick(); settle();
    check("bp_after_vld0", bus.rsp0_valid, 0);
    check("bp_after_rdy1", bus.req1_ready, 1);
    tick(); drive_req(1, 1'b0, 4'b0000, 32'd0, 32'd0);
    tick(); settle();
    check("bp_rsp1_vld", bus.rsp1_valid, 1);
    check("bp_rsp1_data", bus.rsp1_data, 32'd0);
    check("bp_rsp1_flag", bus.rsp1_flag, 4'b0001);
    tick();

    // Reset during EXEC of a port 0 op.
    tick(); drive_req(0, 1'b1, 4'b0000, 32'd50, 32'd60); settle();
    check("rmid_rdy0", bus.req0_ready, 1);
    tick(); drive_req(0, 1'b0, 4'b0000, 32'd0, 32'd0); settle();
    check("rmid_alu_a", bus.alu_a, 32'd50);
    #1 rst_n = 1'b0;
    #1;
    check("rmid_alu_a_clr", bus.alu_a, 0);
    check("rmid_rsp_data_clr", {bus.rsp0_data, bus.rsp1_data}, 0);
    check("rmid_rsp_flag_clr", {bus.rsp0_flag, bus.rsp1_flag}, 0);
    check("rmid_vld_clr", {bus.rsp0_valid, bus.rsp1_valid}, 0);
    tick(); tick();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      settle();
      check("rmid_no_rsp", {bus.rsp0_valid, bus.rsp1_valid}, 0);
      tick();
    end
    drive_req(0, 1'b1, 4'b0010, 32'd6, 32'd3);
    drive_req(1, 1'b1, 4'b0000, 32'd1, 32'd1);
    settle();
    check("rmid_tie_rdy0", bus.req0_ready, 1);
    check("rmid_tie_rdy1", bus.req1_ready, 0);
    tick();
    drive_req(0, 1'b0, 4'b0000, 32'd0, 32'd0);
    drive_req(1, 1'b0, 4'b0000, 32'd0, 32'd0);
    tick(); settle();
    check("rmid_tie_vld", bus.rsp0_valid, 1);
    check("rmid_tie_data", bus.rsp0_data, 32'd2);
    check("rmid_tie_flag", bus.rsp0_flag, 4'b0000);
    tick();

`ifdef ALU_ILLEGAL_OP_CHK_EN
    tick(); drive_req(0, 1'b1, 4'b0100, 32'd77, 32'd88); settle();
    check("ill_rdy0", bus.req0_ready, 1);
    tick(); drive_req(0, 1'b0, 4'b0000, 32'd0, 32'd0); settle();
    check("ill_vld", bus.rsp0_valid, 1);
    check("ill_err", bus.rsp0_err, 1);
    check("ill_data", bus.rsp0_data, 0);
    check("ill_alu_ctrl", bus.alu_ctrl, 4'b0010);
    check("ill_alu_a", bus.alu_a, 32'd6);
    tick(); settle();
    check("ill_vld_drop", bus.rsp0_valid, 0);
    run_op("legal_after_ill", 0, 4'b0000, 32'd2, 32'd2, 32'd4, 4'b0000);
    check("legal_err", bus.rsp0_err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1);
  end
endmodule
